// File: rtl/vector_sweep_engine.sv
// Sweeps a programmable index range onto a DUT, samples its response per vector and streams records.
// Define VECTOR_SWEEP_MISR_EN to build the MISR signature and golden compare; otherwise both read 0.
module vector_sweep_engine #(
    parameter int unsigned       N_W       = 8,
    parameter int unsigned       OUT_W     = 1,
    parameter int unsigned       SETTLE    = 1,
    parameter int unsigned       MISR_W    = 16,
    parameter logic [MISR_W-1:0] MISR_POLY = 16'h8016
) (
    input  logic              CK,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              pause,
    input  logic              gray_mode,
    input  logic [N_W-1:0]    first_idx,
    input  logic [N_W-1:0]    last_idx,
    output logic [N_W-1:0]    dut_in,
    input  logic [OUT_W-1:0]  dut_out,
    output logic              sample_valid,
    output logic [N_W-1:0]    sample_vec,
    output logic [OUT_W-1:0]  sample_resp,
    output logic              busy,
    output logic              done,
    output logic [MISR_W-1:0] signature,
    input  logic [MISR_W-1:0] golden,
    output logic              pass
);

    localparam int unsigned      CNT_W   = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE);

    typedef enum logic [1:0] {StIdle, StApply, StDone} state_e;

    state_e state_q, state_d;

    logic [N_W-1:0]   idx_q, idx_d;
    logic [N_W-1:0]   last_q, last_d;
    logic             gray_q, gray_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sample_valid_q, sample_valid_d;
    logic [N_W-1:0]   sample_vec_q, sample_vec_d;
    logic [OUT_W-1:0] sample_resp_q, sample_resp_d;
    logic             done_q, done_d;

    logic             go;
    logic             capture;
    logic             is_last;
    logic [N_W-1:0]   vec_enc;

    assign go      = (state_q == StIdle) && start && !abort;
    // The final hold edge of a vector; abort and pause both suppress it.
    assign capture = (state_q == StApply) && !abort && !pause && (cnt_q == CNT_MAX);
    assign is_last = (idx_q == last_q);
    assign vec_enc = gray_q ? (idx_q ^ (idx_q >> 1)) : idx_q;

    always_ff @(posedge CK) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (go) state_d = StApply;
            end
            StApply: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (capture && is_last) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy   = (state_q != StIdle);
        dut_in = vec_enc;
    end

    always_comb begin
        idx_d          = idx_q;
        last_d         = last_q;
        gray_d         = gray_q;
        cnt_d          = cnt_q;
        sample_valid_d = capture;
        sample_vec_d   = capture ? vec_enc : sample_vec_q;
        sample_resp_d  = capture ? dut_out : sample_resp_q;
        done_d         = (state_q == StDone) && !abort;
        if (go) begin
            idx_d  = first_idx;
            last_d = last_idx;
            gray_d = gray_mode;
            cnt_d  = '0;
        end else if ((state_q == StApply) && !abort && !pause) begin
            if (capture) begin
                cnt_d = '0;
                if (!is_last) idx_d = idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CK) begin
        if (!reset) begin
            idx_q          <= '0;
            last_q         <= '0;
            gray_q         <= 1'b0;
            cnt_q          <= '0;
            sample_valid_q <= 1'b0;
            sample_vec_q   <= '0;
            sample_resp_q  <= '0;
            done_q         <= 1'b0;
        end else begin
            idx_q          <= idx_d;
            last_q         <= last_d;
            gray_q         <= gray_d;
            cnt_q          <= cnt_d;
            sample_valid_q <= sample_valid_d;
            sample_vec_q   <= sample_vec_d;
            sample_resp_q  <= sample_resp_d;
            done_q         <= done_d;
        end
    end

    assign sample_valid = sample_valid_q;
    assign sample_vec   = sample_vec_q;
    assign sample_resp  = sample_resp_q;
    assign done         = done_q;

`ifdef VECTOR_SWEEP_MISR_EN
    logic [MISR_W-1:0] sig_q, sig_d, sig_next;
    logic              pass_q, pass_d;

    always_comb begin
        sig_next = {sig_q[MISR_W-2:0], 1'b0}
                 ^ (sig_q[MISR_W-1] ? MISR_POLY : {MISR_W{1'b0}})
                 ^ MISR_W'(dut_out);
        sig_d  = sig_q;
        pass_d = pass_q;
        if (go) begin
            sig_d  = '0;
            pass_d = 1'b0;
        end else if (capture) begin
            sig_d = sig_next;
        end
        // No capture happens in DONE, so sig_q is already final here.
        if (done_d) pass_d = (sig_q == golden);
    end

    always_ff @(posedge CK) begin
        if (!reset) begin
            sig_q  <= '0;
            pass_q <= 1'b0;
        end else begin
            sig_q  <= sig_d;
            pass_q <= pass_d;
        end
    end

    assign signature = sig_q;
    assign pass      = pass_q;
`else
    logic unused_golden;
    assign unused_golden = ^golden;
    assign signature     = '0;
    assign pass          = 1'b0;
`endif

endmodule

// File: tb/tb_vector_sweep_engine.sv
// Randomized scoreboard bench for vector_sweep_engine: stimulus queues expected records,
// a negedge monitor pops and compares them against sample_valid and done.
module tb_vector_sweep_engine;

    localparam int HOLD = 3;  // SETTLE + 1 for the instance below

    typedef struct {
        logic [7:0] vec;
        logic [3:0] resp;
        int         cyc;
    } rec_t;

    typedef struct {
        int          cyc;
        logic [15:0] sig;
        logic        pass;
    } done_t;

    logic        CK = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        pause = 1'b0;
    logic        gray_mode = 1'b0;
    logic [7:0]  first_idx = '0;
    logic [7:0]  last_idx = '0;
    logic [7:0]  dut_in;
    logic [3:0]  dut_out;
    logic        sample_valid;
    logic [7:0]  sample_vec;
    logic [3:0]  sample_resp;
    logic        busy;
    logic        done;
    logic [15:0] signature;
    logic [15:0] golden = '0;
    logic        pass;

    vector_sweep_engine #(
        .N_W      (8),
        .OUT_W    (4),
        .SETTLE   (2),
        .MISR_W   (16),
        .MISR_POLY(16'h8016)
    ) dut (
        .CK          (CK),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .pause       (pause),
        .gray_mode   (gray_mode),
        .first_idx   (first_idx),
        .last_idx    (last_idx),
        .dut_in      (dut_in),
        .dut_out     (dut_out),
        .sample_valid(sample_valid),
        .sample_vec  (sample_vec),
        .sample_resp (sample_resp),
        .busy        (busy),
        .done        (done),
        .signature   (signature),
        .golden      (golden),
        .pass        (pass)
    );

    always #5 CK = ~CK;

    int cyc = 0;
    always @(posedge CK) cyc <= cyc + 1;

    int         resp_mode = 0;
    logic [3:0] salt = '0;

    function automatic logic [3:0] model_resp(input logic [7:0] v, input int mode,
                                              input logic [3:0] s);
        case (mode)
            0:       return {3'b000, ^v};
            1:       return 4'h0;
            default: return v[3:0] ^ v[7:4] ^ s;
        endcase
    endfunction

    always_comb dut_out = model_resp(dut_in, resp_mode, salt);

    function automatic logic [7:0] enc(input logic [7:0] i, input logic g);
        return g ? (i ^ (i >> 1)) : i;
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [3:0] r);
        logic [15:0] n;
        n = {s[14:0], 1'b0} ^ {12'h000, r};
        if (s[15]) n = n ^ 16'h8016;
        return n;
    endfunction

    // Signature after the first n vectors of a sweep (n < 0 means the whole range).
    function automatic logic [15:0] sweep_sig(input logic [7:0] f, input logic [7:0] l,
                                              input logic g, input int n);
        logic [15:0] s;
        int          v;
        s = '0;
        v = int'(8'(l - f)) + 1;
        if (n >= 0 && n < v) v = n;
        for (int k = 0; k < v; k++) s = misr_step(s, model_resp(enc(8'(f + k), g), resp_mode, salt));
        return s;
    endfunction

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    rec_t  exp_q[$];
    done_t done_q[$];
    rec_t  mon_r;
    done_t mon_d;
    int    seen = 0;
    logic  chk_gray = 1'b0;
    logic  have_prev = 1'b0;
    logic [7:0] prev_vec = '0;

    always @(negedge CK) begin
        if (sample_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sample", 32'(1), 32'(0));
            end else begin
                mon_r = exp_q.pop_front();
                check("sample_vec", 32'(sample_vec), 32'(mon_r.vec));
                check("sample_resp", 32'(sample_resp), 32'(mon_r.resp));
                check("sample_cycle", 32'(cyc), 32'(mon_r.cyc));
                if (chk_gray && have_prev)
                    check("gray_one_bit", 32'($countones(prev_vec ^ sample_vec)), 32'(1));
                prev_vec  = sample_vec;
                have_prev = 1'b1;
                seen++;
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                check("unexpected_done", 32'(1), 32'(0));
            end else begin
                mon_d = done_q.pop_front();
                check("done_cycle", 32'(cyc), 32'(mon_d.cyc));
                check("signature", 32'(signature), 32'(mon_d.sig));
                check("pass", 32'(pass), 32'(mon_d.pass));
                check("busy_at_done", 32'(busy), 32'(0));
                check("records_before_done", 32'(exp_q.size()), 32'(0));
            end
        end
    end

    task automatic start_sweep(input logic [7:0] f, input logic [7:0] l, input logic g,
                               input logic [15:0] gold, input int pause_k);
        int          v;
        int          e0;
        int          dly;
        logic [15:0] s;
        rec_t        r;
        done_t       d;
        @(negedge CK);
        first_idx = f;
        last_idx  = l;
        gray_mode = g;
        golden    = gold;
        start     = 1'b1;
        e0        = cyc + 1;
        v         = int'(8'(l - f)) + 1;
        s         = '0;
        dly       = 0;
        for (int k = 0; k < v; k++) begin
            if (pause_k >= 0 && k >= pause_k) dly = 5;
            r.vec  = enc(8'(f + k), g);
            r.resp = model_resp(r.vec, resp_mode, salt);
            r.cyc  = e0 + (k + 1) * HOLD + dly;
            exp_q.push_back(r);
            s = misr_step(s, r.resp);
        end
        d.cyc = e0 + v * HOLD + 1 + dly;
`ifdef VECTOR_SWEEP_MISR_EN
        d.sig  = s;
        d.pass = (s == gold);
`else
        d.sig  = '0;
        d.pass = 1'b0;
`endif
        done_q.push_back(d);
        seen      = 0;
        have_prev = 1'b0;
        chk_gray  = g;
        @(negedge CK);
        start = 1'b0;
        if (pause_k >= 0) begin
            while (cyc < e0 + pause_k * HOLD) @(negedge CK);
            pause = 1'b1;
            repeat (5) @(negedge CK);
            pause = 1'b0;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0 || busy) && n < budget) begin
            @(negedge CK);
            n++;
        end
        if (n >= budget) begin
            check("sweep_timeout", 32'(1), 32'(0));
            exp_q.delete();
            done_q.delete();
        end
        repeat (2) @(negedge CK);
    endtask

    logic [7:0]  f_r;
    logic [15:0] g_r;
    int          n_w;

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge CK);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_valid", 32'(sample_valid), 32'(0));
        check("rst_dut_in", 32'(dut_in), 32'(0));
        check("rst_signature", 32'(signature), 32'(0));
        check("rst_pass", 32'(pass), 32'(0));
        reset = 1'b1;
        repeat (2) @(negedge CK);

        // Full binary sweep with parity response
        resp_mode = 0;
        start_sweep(8'd0, 8'd255, 1'b0, 16'($urandom), -1);
        wait_idle(3000);

        // Gray order
        resp_mode = 2;
        salt      = 4'($urandom);
        start_sweep(8'd0, 8'd7, 1'b1, 16'h0, -1);
        wait_idle(200);

        // Wrap-around, with a start pulse while busy that must be ignored
        salt = 4'($urandom);
        start_sweep(8'd254, 8'd1, 1'b0, 16'h0, -1);
        first_idx = 8'h10;
        last_idx  = 8'h20;
        start     = 1'b1;
        @(negedge CK);
        start = 1'b0;
        wait_idle(200);

        // Single vector
        start_sweep(8'd77, 8'd77, 1'b1, 16'h0, -1);
        wait_idle(100);

        // Pause mid-settle of the fourth vector
        salt = 4'($urandom);
        start_sweep(8'd10, 8'd17, 1'b0, 16'h0, 3);
        wait_idle(200);

        // Zero response: signature stays 0
        resp_mode = 1;
        start_sweep(8'd0, 8'd15, 1'b0, 16'h0000, -1);
        wait_idle(200);
        start_sweep(8'd0, 8'd15, 1'b0, 16'h0001, -1);
        wait_idle(200);

        // Golden equal to the model signature
        resp_mode = 2;
        salt      = 4'($urandom);
        f_r       = 8'($urandom);
        g_r       = sweep_sig(f_r, 8'(f_r + 20), 1'b1, -1);
        start_sweep(f_r, 8'(f_r + 20), 1'b1, g_r, -1);
        wait_idle(300);

        // Abort after 10 samples
        salt = 4'($urandom);
        f_r  = 8'($urandom);
        start_sweep(f_r, 8'(f_r + 40), 1'b0, 16'h0, -1);
        n_w = 0;
        while (seen < 10 && n_w < 500) begin
            @(negedge CK);
            n_w++;
        end
        check("abort_reached_10", 32'(seen >= 10), 32'(1));
        abort = 1'b1;
        @(negedge CK);
        abort = 1'b0;
        exp_q.delete();
        done_q.delete();
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_dut_in_hold", 32'(dut_in), 32'(8'(f_r + 10)));
`ifdef VECTOR_SWEEP_MISR_EN
        g_r = sweep_sig(f_r, 8'(f_r + 40), 1'b0, 10);
`else
        g_r = '0;
`endif
        check("abort_sig_hold", 32'(signature), 32'(g_r));
        repeat (12) @(negedge CK);
        check("abort_still_idle", 32'(busy), 32'(0));
        check("abort_sig_later", 32'(signature), 32'(g_r));

        // start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        @(negedge CK);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", 32'(busy), 32'(0));
        repeat (4) @(negedge CK);

        // Reset mid-sweep
        start_sweep(8'd100, 8'd200, 1'b0, 16'h0, -1);
        n_w = 0;
        while (seen < 5 && n_w < 500) begin
            @(negedge CK);
            n_w++;
        end
        reset = 1'b0;
        @(negedge CK);
        reset = 1'b1;
        exp_q.delete();
        done_q.delete();
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_sig", 32'(signature), 32'(0));
        check("mid_rst_dut_in", 32'(dut_in), 32'(0));
        check("mid_rst_pass", 32'(pass), 32'(0));
        repeat (8) @(negedge CK);

        // Restart from a new first index; signature reseeded
        salt = 4'($urandom);
        g_r  = sweep_sig(8'd30, 8'd35, 1'b0, -1);
        start_sweep(8'd30, 8'd35, 1'b0, g_r, -1);
        wait_idle(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
